// File: rtl/gpio_board_input_scanner_pkg.sv
// Shared definitions for the GPIO board input scanner: scan FSM states and
// the default bank geometry that the GPIO_Board output driver also uses.
package gpio_board_input_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_UPDATE = 2'd2
  } scan_state_e;

  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_BANK_WIDTH = 8;

endpackage

// File: rtl/gpio_board_input_scanner_debounce_bank.sv
// One bank's debouncer: tracks the last sample and a saturating match count,
// and accepts a new stable value once it has been seen DEBOUNCE_SCANS times.
module gpio_board_input_scanner_debounce_bank #(
  parameter int BW             = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [BW-1:0] raw_i,
  output logic [BW-1:0] stable_o,
  output logic [BW-1:0] rise_o,
  output logic [BW-1:0] fall_o
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [BW-1:0] last_q, last_d, stable_q, stable_d;
  logic [BW-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    last_d   = last_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    if (en_i) begin
      if (raw_i != last_q) begin
        last_d = raw_i;
        cnt_d  = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Acceptance uses the updated count so the Nth matching sample commits.
      if (cnt_d == CNT_MAX && raw_i != stable_q) begin
        stable_d = raw_i;
        rise_d   = raw_i & ~stable_q;
        fall_d   = ~raw_i & stable_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/gpio_board_input_scanner.sv
// Scans a bank-multiplexed active-low switch array: settle, sample, update per
// bank, with debounced state and one-cycle press/release/changed/scan_done pulses.
module gpio_board_input_scanner
  import gpio_board_input_scanner_pkg::*;
#(
  parameter int NUM_BANKS      = DEF_NUM_BANKS,
  parameter int BANK_WIDTH     = DEF_BANK_WIDTH,
  parameter int SETTLE_CYCLES  = 64,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int SEL_W         = $clog2(NUM_BANKS),
  localparam int NB            = NUM_BANKS * BANK_WIDTH
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic [BANK_WIDTH-1:0] gpio_in,
  output logic [SEL_W-1:0]      bank_sel,
  output logic [NB-1:0]         switches,
  output logic [NB-1:0]         press_pulse,
  output logic [NB-1:0]         release_pulse,
  output logic                  changed,
  output logic                  scan_done
);

  localparam int               SCW         = $clog2(SETTLE_CYCLES);
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_BANKS - 1);

  scan_state_e                      state_q, state_d;
  logic [SCW-1:0]                   settle_q, settle_d;
  logic [SEL_W-1:0]                 bank_sel_q, bank_sel_d;
  logic                             done_q, done_d;
  logic [1:0][BANK_WIDTH-1:0]       sync_q;
  logic [BANK_WIDTH-1:0]            sample_q, sample_d;

  logic [NUM_BANKS-1:0]                 bank_en;
  logic [NUM_BANKS-1:0][BANK_WIDTH-1:0] stable, rise, fall;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    bank_sel_d = bank_sel_q;
    sample_d   = sample_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        sample_d = ~sync_q[1];
        state_d  = ST_UPDATE;
      end
      ST_UPDATE: begin
        bank_sel_d = bank_sel_q + 1'b1;
        done_d     = (bank_sel_q == SEL_LAST);
        state_d    = ST_SETTLE;
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_SETTLE;
      settle_q   <= '0;
      bank_sel_q <= '0;
      done_q     <= 1'b0;
      sync_q     <= '0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      bank_sel_q <= bank_sel_d;
      done_q     <= done_d;
      sync_q     <= {sync_q[0], gpio_in};
      sample_q   <= sample_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_en[b] = (state_q == ST_UPDATE) && (bank_sel_q == SEL_W'(b));

    gpio_board_input_scanner_debounce_bank #(
      .BW            (BANK_WIDTH),
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_bank (
      .clk     (CLOCK_50),
      .rst_n   (reset_n),
      .en_i    (bank_en[b]),
      .raw_i   (sample_q),
      .stable_o(stable[b]),
      .rise_o  (rise[b]),
      .fall_o  (fall[b])
    );
  end

  assign bank_sel      = bank_sel_q;
  assign switches      = stable;
  assign press_pulse   = rise;
  assign release_pulse = fall;
  assign changed       = |{rise, fall};
  assign scan_done     = done_q;

endmodule
